// File: rtl/mmio_host_sequencer.sv
// Serializes one CMD/ADDR/ARG/MMVR command into 15 byte-wide MMIO writes ending on the doorbell.
// It then optionally polls STATUS against a mask/match or a timeout, and holds the result on a valid/ready response port.
module mmio_host_sequencer #(
    parameter int MMIO_AW    = 8,
    parameter int DW         = 8,
    parameter int ADDR_W     = 16,
    parameter int ARG_W      = 32,
    parameter int BUF_W      = 64,
    parameter int REG_STATUS = 0,
    parameter int REG_CMD    = 1,
    parameter int REG_ADDR   = 2,
    parameter int REG_ARG    = 4,
    parameter int REG_MMVR   = 8,
    parameter int SETTLE     = 2,
    parameter int TMO_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DW-1:0]      req_cmd,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [ARG_W-1:0]   req_arg,
    input  logic [BUF_W-1:0]   req_mmvr,
    input  logic               req_poll,
    input  logic [DW-1:0]      req_mask,
    input  logic [DW-1:0]      req_match,
    input  logic [TMO_W-1:0]   req_timeout,
    output logic [MMIO_AW-1:0] host_addr,
    output logic [DW-1:0]      host_wr_data,
    output logic               host_wr_en,
    input  logic [DW-1:0]      host_rd_data,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DW-1:0]      resp_status,
    output logic               resp_timeout,
    output logic               busy
);

    localparam int NA = ADDR_W / DW;
    localparam int NG = ARG_W / DW;
    localparam int NM = BUF_W / DW;
    localparam int NW = 1 + NA + NG + NM;

    typedef enum logic [1:0] {IDLE, WRITE, POLL, RESP} state_t;

    state_t               state, state_nx;
    logic [3:0]           idx, idx_nx;
    logic [TMO_W-1:0]     pcnt, pcnt_nx;
    logic [MMIO_AW-1:0]   addr_nx;
    logic [DW-1:0]        wdat_nx, status_nx;
    logic                 wen_nx, rvld_nx, rtmo_nx, accept;

    logic [DW-1:0]        cmd_q, mask_q, match_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ARG_W-1:0]     arg_q;
    logic [BUF_W-1:0]     mmvr_q;
    logic                 poll_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [NW-1:0][DW-1:0] img;
    logic                 hit, expired;

    // Byte k of the register image lives at img[k], LSB lane first within each field.
    assign img = {mmvr_q, arg_q, addr_q, cmd_q};

    function automatic logic [MMIO_AW-1:0] wr_addr(input logic [3:0] k);
        int ki;
        ki = int'(k);
        if (ki == 0)       return MMIO_AW'(REG_CMD);
        if (ki <= NA)      return MMIO_AW'(REG_ADDR + ki - 1);
        if (ki <= NA + NG) return MMIO_AW'(REG_ARG + ki - 1 - NA);
        return MMIO_AW'(REG_MMVR + ki - 1 - NA - NG);
    endfunction

    assign hit     = (pcnt >= TMO_W'(SETTLE)) &&
                     ((host_rd_data & mask_q) == (match_q & mask_q));
    assign expired = (tmo_q != '0) && (pcnt == tmo_q - TMO_W'(1));

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        pcnt_nx   = pcnt;
        addr_nx   = MMIO_AW'(REG_STATUS);
        wdat_nx   = '0;
        wen_nx    = 1'b0;
        rvld_nx   = resp_valid;
        status_nx = resp_status;
        rtmo_nx   = resp_timeout;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    state_nx = WRITE;
                    idx_nx   = '0;
                    addr_nx  = wr_addr(4'd0);
                    wdat_nx  = req_cmd;
                    wen_nx   = 1'b1;
                end
            end
            WRITE: begin
                if (idx == 4'(NW - 1)) begin
                    pcnt_nx = '0;
                    if (poll_q) begin
                        state_nx = POLL;
                    end else begin
                        state_nx  = RESP;
                        rvld_nx   = 1'b1;
                        status_nx = '0;
                        rtmo_nx   = 1'b0;
                    end
                end else begin
                    idx_nx  = idx + 4'd1;
                    addr_nx = wr_addr(idx_nx);
                    wdat_nx = img[idx_nx];
                    wen_nx  = 1'b1;
                end
            end
            POLL: begin
                status_nx = host_rd_data;
                pcnt_nx   = (pcnt == '1) ? pcnt : pcnt + TMO_W'(1);
                // A match on the same sample as the timeout still reports success.
                if (hit || expired) begin
                    state_nx = RESP;
                    rvld_nx  = 1'b1;
                    rtmo_nx  = !hit;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                    rvld_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            pcnt         <= '0;
            host_addr    <= MMIO_AW'(REG_STATUS);
            host_wr_data <= '0;
            host_wr_en   <= 1'b0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_status  <= '0;
            resp_timeout <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            pcnt         <= pcnt_nx;
            host_addr    <= addr_nx;
            host_wr_data <= wdat_nx;
            host_wr_en   <= wen_nx;
            req_ready    <= (state_nx == IDLE);
            resp_valid   <= rvld_nx;
            resp_status  <= status_nx;
            resp_timeout <= rtmo_nx;
            busy         <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            addr_q  <= '0;
            arg_q   <= '0;
            mmvr_q  <= '0;
            poll_q  <= 1'b0;
            mask_q  <= '0;
            match_q <= '0;
            tmo_q   <= '0;
        end else if (accept) begin
            cmd_q   <= req_cmd;
            addr_q  <= req_addr;
            arg_q   <= req_arg;
            mmvr_q  <= req_mmvr;
            poll_q  <= req_poll;
            mask_q  <= req_mask;
            match_q <= req_match;
            tmo_q   <= req_timeout;
        end
    end

endmodule

// File: tb/tb_mmio_host_sequencer.sv
// Bench for mmio_host_sequencer: directed vector table, reset and hold sequences, random transactions vs a poll model.
module tb_mmio_host_sequencer;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_cmd = '0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_arg = '0;
    logic [63:0] req_mmvr = '0;
    logic        req_poll = 1'b0;
    logic [7:0]  req_mask = '0;
    logic [7:0]  req_match = '0;
    logic [15:0] req_timeout = '0;
    logic [7:0]  host_addr;
    logic [7:0]  host_wr_data;
    logic        host_wr_en;
    logic [7:0]  host_rd_data;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [7:0]  resp_status;
    logic        resp_timeout;
    logic        busy;

    logic [7:0]  stat_seq [64];
    int          pc = 0;
    int          npass = 0;
    int          ntot = 0;

    assign host_rd_data = (host_addr == 8'd0) ? stat_seq[pc & 63] : 8'h00;

    always #5 clk = ~clk;

    mmio_host_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_arg(req_arg), .req_mmvr(req_mmvr),
        .req_poll(req_poll), .req_mask(req_mask), .req_match(req_match), .req_timeout(req_timeout),
        .host_addr(host_addr), .host_wr_data(host_wr_data), .host_wr_en(host_wr_en),
        .host_rd_data(host_rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .resp_timeout(resp_timeout), .busy(busy)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [31:0] arg;
        logic [63:0] mmvr;
        logic        poll;
        logic [7:0]  mask;
        logic [7:0]  match;
        logic [15:0] tmo;
        logic [7:0]  st_base;
        logic [7:0]  st_hit;
        int          st_from;
        int          exp_np;
        logic [7:0]  exp_st;
        logic        exp_to;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Reference poll outcome straight from the sampling rules, cycle by cycle.
    task automatic model_poll(input logic poll, input logic [7:0] mask, input logic [7:0] match,
                              input logic [15:0] tmo, output int np, output logic [7:0] st,
                              output logic to);
        np = -1; st = 8'h00; to = 1'b0;
        if (!poll) begin
            np = 0;
            return;
        end
        for (int p = 0; p < 64; p++) begin
            if (p >= SETTLE && ((stat_seq[p] ^ match) & mask) == 8'h00) begin
                np = p + 1; st = stat_seq[p]; to = 1'b0;
                return;
            end
            if (tmo != 16'd0 && p == int'(tmo) - 1) begin
                np = p + 1; st = stat_seq[p]; to = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_txn(input logic [7:0] cmd, input logic [15:0] addr, input logic [31:0] arg,
                          input logic [63:0] mmvr, input logic poll, input logic [7:0] mask,
                          input logic [7:0] match, input logic [15:0] tmo, input int hold,
                          input int exp_np, input logic [7:0] exp_st, input logic exp_to);
        logic [119:0] img, sh;
        logic [7:0]   st0;
        int           nwr, npl, c;
        logic         wr_ok, hold_ok;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        pc = 0;
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_arg = arg; req_mmvr = mmvr;
        req_poll = poll; req_mask = mask; req_match = match; req_timeout = tmo;
        @(negedge clk);
        req_valid = 1'b0;
        req_cmd = 8'($urandom); req_addr = 16'($urandom); req_arg = $urandom;
        req_mmvr = {$urandom, $urandom}; req_poll = 1'($urandom); req_mask = 8'($urandom);
        req_match = 8'($urandom); req_timeout = 16'($urandom);
        img = {mmvr, arg, addr, cmd};
        nwr = 0; npl = 0; c = 0; wr_ok = 1'b1;
        while (!resp_valid && c < 600) begin
            if (host_wr_en) begin
                sh = img >> (8 * nwr);
                if (nwr != c || nwr >= 15 || host_addr != 8'(nwr + 1) || host_wr_data != sh[7:0])
                    wr_ok = 1'b0;
                nwr++;
            end else if (busy) begin
                if (host_addr != 8'd0) wr_ok = 1'b0;
                pc = npl;
                npl++;
            end else begin
                wr_ok = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        chk("resp_seen", resp_valid, 1);
        chk("write_seq", wr_ok, 1);
        chk("write_count", nwr, 15);
        chk("poll_cycles", npl, exp_np);
        chk("resp_latency", c, 15 + exp_np);
        chk("resp_status", resp_status, exp_st);
        chk("resp_timeout", resp_timeout, exp_to);
        if (!resp_valid) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        st0 = resp_status;
        hold_ok = 1'b1;
        repeat (hold) begin
            req_valid = 1'b1;
            req_cmd = 8'($urandom);
            @(negedge clk);
            if (!(resp_valid && resp_status == st0 && !req_ready && !host_wr_en && busy))
                hold_ok = 1'b0;
        end
        chk("resp_hold", hold_ok, 1);
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_release", {resp_valid, busy, req_ready}, 3'b001);
    endtask

    vec_t vecs [8];

    initial begin
        int         np, n;
        logic [7:0] st;
        logic       to;
        logic [7:0] mk, mt;
        logic [15:0] tm;

        vecs[0] = '{8'h03, 16'h1234, 32'hA1B2C3D4, 64'h0807060504030201, 1'b0, 8'h01, 8'h01, 16'd0,
                    8'h3C, 8'h3C, 0, 0, 8'h00, 1'b0};
        vecs[1] = '{8'h11, 16'hBEEF, 32'h01020304, 64'h1122334455667788, 1'b1, 8'h01, 8'h01, 16'd0,
                    8'h01, 8'h01, 0, 3, 8'h01, 1'b0};
        vecs[2] = '{8'h22, 16'h0001, 32'hFFFFFFFF, 64'h0, 1'b1, 8'h01, 8'h01, 16'd10,
                    8'h00, 8'h00, 0, 10, 8'h00, 1'b1};
        vecs[3] = '{8'h33, 16'h8000, 32'h0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 8'h01, 8'h01, 16'd10,
                    8'h00, 8'h01, 9, 10, 8'h01, 1'b0};
        vecs[4] = '{8'h44, 16'h5555, 32'hAAAA5555, 64'hDEADBEEFCAFEF00D, 1'b1, 8'h00, 8'hFF, 16'd0,
                    8'h5A, 8'h5A, 0, 3, 8'h5A, 1'b0};
        vecs[5] = '{8'h55, 16'h0F0F, 32'h12345678, 64'h0123456789ABCDEF, 1'b1, 8'h01, 8'h01, 16'd6,
                    8'h01, 8'h00, 2, 6, 8'h00, 1'b1};
        vecs[6] = '{8'h66, 16'hF00F, 32'h87654321, 64'hA5A5A5A55A5A5A5A, 1'b1, 8'h01, 8'h01, 16'd1,
                    8'h00, 8'h00, 0, 1, 8'h00, 1'b1};
        vecs[7] = '{8'h77, 16'h2468, 32'h13579BDF, 64'h0F1E2D3C4B5A6978, 1'b1, 8'hF0, 8'hA0, 16'd0,
                    8'h07, 8'hA7, 5, 6, 8'hA7, 1'b0};

        for (int i = 0; i < 64; i++) stat_seq[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {req_ready, host_wr_en, host_addr, host_wr_data, resp_valid, resp_status, resp_timeout, busy},
            {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0});
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int p = 0; p < 64; p++)
                stat_seq[p] = (p >= vecs[v].st_from) ? vecs[v].st_hit : vecs[v].st_base;
            do_txn(vecs[v].cmd, vecs[v].addr, vecs[v].arg, vecs[v].mmvr, vecs[v].poll,
                   vecs[v].mask, vecs[v].match, vecs[v].tmo, (v == 0) ? 5 : 1,
                   vecs[v].exp_np, vecs[v].exp_st, vecs[v].exp_to);
        end

        // Reset while the write burst is at idx 5, then replay a full transaction.
        @(negedge clk);
        req_valid = 1'b1; req_cmd = 8'h99; req_addr = 16'hABCD; req_arg = 32'h11223344;
        req_mmvr = 64'h55AA55AA55AA55AA; req_poll = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(host_wr_en && host_addr == 8'd6) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_at_idx5", {host_wr_en, host_addr, host_wr_data}, {1'b1, 8'd6, 8'hB2 ^ 8'hB2 ^ 8'h22});
        rst_n = 1'b0;
        #1;
        chk("rst_async", {host_wr_en, host_addr, busy, req_ready, resp_valid},
            {1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release", {busy, req_ready}, 2'b01);
        do_txn(8'h99, 16'hABCD, 32'h11223344, 64'h55AA55AA55AA55AA, 1'b0, 8'h00, 8'h00, 16'd0,
               2, 0, 8'h00, 1'b0);

        for (int r = 0; r < 20; r++) begin
            mk = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
            mt = 8'($urandom);
            tm = 16'($urandom_range(0, 20));
            for (int p = 0; p < 64; p++)
                stat_seq[p] = ($urandom % 4 == 0) ? (mt ^ (8'($urandom) & ~mk)) : 8'($urandom);
            if (tm == 16'd0) stat_seq[$urandom_range(SETTLE, 30)] = mt;
            to = 1'b0;
            st = 8'h00;
            model_poll(($urandom % 4) != 0 ? 1'b1 : 1'b0, mk, mt, tm, np, st, to);
            do_txn(8'($urandom), 16'($urandom), $urandom, {$urandom, $urandom}, (np != 0),
                   mk, mt, tm, $urandom_range(0, 5), np, st, to);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", npass, ntot);
        $fatal(1);
    end

endmodule
